mem_loader: RTL and testbench

Sequential write-side loader for the team's 1 KB byte-wide memory array (1024 × 8, 10-bit address, registered read data with one-cycle latency). It accepts a byte stream on a valid/ready handshake and writes the bytes to consecutive addresses starting from a programmed base address. It computes a running 8-bit checksum and signals completion. The optional verify pass reads the region back through the memory's read port and compares checksums.

---
 rtl/mem_loader_if.sv | 32 +++
 rtl/mem_loader.sv | 187 ++++++++++++++++++
 tb/tb_mem_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_if.sv
// mem_loader_if: control, byte-stream and memory-port signals of the
// sequential memory loader, bundled with master (driver) and slave (loader)
// views.
interface mem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;
  logic              error;

  modport master (
    output start, base_addr, len, in_valid, in_data, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum, error
  );

  modport slave (
    input  start, base_addr, len, in_valid, in_data, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum, error
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: writes a valid/ready byte stream to consecutive addresses of a
// 2^ADDR_W x DATA_W memory starting at a programmed base, keeping a running
// mod-2^DATA_W checksum. Optional read-back verify pass is enabled by the
// macro MEM_LOADER_VERIFY_EN; without it error stays 0 and mem_rdata is unused.
module mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  mem_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    DRAIN  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   wr_cnt_inc;
  logic              hs;

`ifdef MEM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] vptr;
  logic [ADDR_W:0]   vcnt;
  logic              addr_valid;  // mem_addr currently carries a read address
  logic              rd_pend;     // mem_rdata this cycle answers last cycle's read
  logic [DATA_W-1:0] vsum;
  logic [DATA_W-1:0] vsum_next;

  assign vsum_next = vsum + bus.mem_rdata;
`else
  logic rdata_unused;
  assign rdata_unused = ^bus.mem_rdata;
`endif

  assign bus.in_ready = (state == WRITE);
  assign hs           = bus.in_valid && (state == WRITE);
  assign wr_cnt_inc   = wr_cnt + CNT_ONE;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == {(ADDR_W+1){1'b0}}) begin
            next_state = DONE;
          end else begin
            next_state = WRITE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WRITE: begin
        if (hs && (wr_cnt_inc == len_q)) begin
          next_state = DRAIN;
        end else begin
          next_state = WRITE;
        end
      end
      DRAIN: begin
`ifdef MEM_LOADER_VERIFY_EN
        next_state = VERIFY;
`else
        next_state = DONE;
`endif
      end
`ifdef MEM_LOADER_VERIFY_EN
      VERIFY: begin
        if (rd_pend && !addr_valid) begin
          next_state = DONE;
        end else begin
          next_state = VERIFY;
        end
      end
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs: write port, checksum, status, verify.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.checksum  <= {DATA_W{1'b0}};
      bus.error     <= 1'b0;
      ptr           <= {ADDR_W{1'b0}};
      len_q         <= {(ADDR_W+1){1'b0}};
      wr_cnt        <= {(ADDR_W+1){1'b0}};
`ifdef MEM_LOADER_VERIFY_EN
      base_q        <= {ADDR_W{1'b0}};
      vptr          <= {ADDR_W{1'b0}};
      vcnt          <= {(ADDR_W+1){1'b0}};
      addr_valid    <= 1'b0;
      rd_pend       <= 1'b0;
      vsum          <= {DATA_W{1'b0}};
`endif
    end else begin
      bus.busy   <= (next_state == WRITE) || (next_state == DRAIN) ||
                    (next_state == VERIFY);
      bus.done   <= (next_state == DONE);
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ptr          <= bus.base_addr;
            len_q        <= bus.len;
            wr_cnt       <= {(ADDR_W+1){1'b0}};
            bus.checksum <= {DATA_W{1'b0}};
            bus.error    <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
            base_q       <= bus.base_addr;
`endif
          end
        end
        WRITE: begin
          if (hs) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= bus.in_data;
            ptr           <= ptr + ADDR_ONE;
            wr_cnt        <= wr_cnt_inc;
            bus.checksum  <= bus.checksum + bus.in_data;
          end
        end
`ifdef MEM_LOADER_VERIFY_EN
        DRAIN: begin
          bus.mem_addr <= base_q;
          vptr         <= base_q + ADDR_ONE;
          vcnt         <= CNT_ONE;
          addr_valid   <= 1'b1;
          rd_pend      <= 1'b0;
          vsum         <= {DATA_W{1'b0}};
        end
        VERIFY: begin
          rd_pend <= addr_valid;
          if (rd_pend) begin
            vsum <= vsum_next;
          end
          if (addr_valid) begin
            if (vcnt == len_q) begin
              addr_valid <= 1'b0;
            end else begin
              bus.mem_addr <= vptr;
              vptr         <= vptr + ADDR_ONE;
              vcnt         <= vcnt + CNT_ONE;
            end
          end
          if (rd_pend && !addr_valid) begin
            bus.error <= (vsum_next != bus.checksum);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed-vector scoreboard bench for mem_loader. Stimulus
// pushes expected writes and completions into queues; a negedge monitor pops
// and compares whenever the DUT shows mem_we or done. Works with or without
// MEM_LOADER_VERIFY_EN.
module tb_mem_loader;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int sum;  int err;  } dn_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  wr_t  wq[$];
  dn_t  dq[$];
  logic [7:0] mem [1024];
  bit   corrupt;
  int   corrupt_addr;

  mem_loader_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  mem_loader dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous write, registered read, optional corruption.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr] ^
                     ((corrupt && (int'(bus.mem_addr) == corrupt_addr)) ? 8'h01 : 8'h00);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write and every completion against the queues.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (bus.mem_we) begin
      if (wq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d",
                 bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        w = wq.pop_front();
        check("wr_addr", int'(bus.mem_addr), w.addr);
        check("wr_data", int'(bus.mem_wdata), w.data);
        check("wr_cycle", cyc, w.cyc);
      end
    end
    if (bus.done) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: at cycle %0d", cyc);
      end else begin
        d = dq.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("checksum", int'(bus.checksum), d.sum);
        check("error", int'(bus.error), d.err);
        check("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  int'(bus.in_ready), 0);
    check({tag, "_mem_we"},    int'(bus.mem_we), 0);
    check({tag, "_mem_addr"},  int'(bus.mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(bus.mem_wdata), 0);
    check({tag, "_busy"},      int'(bus.busy), 0);
    check({tag, "_done"},      int'(bus.done), 0);
    check({tag, "_checksum"},  int'(bus.checksum), 0);
    check({tag, "_error"},     int'(bus.error), 0);
  endtask

  // One load: data byte k = d[8k+:8]; vpat bit i = in_valid in cycle i+1.
  task automatic run_load(input int base, input int n, input logic [63:0] d,
                          input logic [15:0] vpat, input int exp_sum,
                          input int exp_err, input bit poke);
    int  t0, c, k, last_hs, budget;
    logic v;
    wr_t w;
    dn_t e;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b1;
    bus.base_addr = 10'(base);
    bus.len = 11'(n);
    bus.in_valid = 1'b0;
    // Expected writes and completion from the valid pattern.
    k = 0; c = 1; last_hs = 0;
    while (k < n) begin
      v = (c <= 16) ? vpat[c-1] : 1'b1;
      if (v) begin
        w.cyc = t0 + c + 1; w.addr = (base + k) % 1024; w.data = int'(d[8*k +: 8]);
        wq.push_back(w);
        k++; last_hs = c;
      end
      c++;
    end
`ifdef MEM_LOADER_VERIFY_EN
    e.cyc = (n == 0) ? t0 + 1 : t0 + last_hs + n + 3;
`else
    e.cyc = (n == 0) ? t0 + 1 : t0 + last_hs + 2;
`endif
    e.sum = exp_sum; e.err = exp_err;
    dq.push_back(e);
    // Drive the stream.
    c = 0; k = 0; budget = 0;
    while (k < n && budget < 100) begin
      @(posedge clk); #1;
      c++; budget++;
      bus.start = poke && (c == 2);
      if (poke && c == 2) begin
        bus.base_addr = 10'h200;
        bus.len = 11'd1;
      end
      bus.in_valid = (c <= 16) ? vpat[c-1] : 1'b1;
      bus.in_data = d[8*k +: 8];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) k++;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    budget = 0;
    while (dq.size() != 0 && budget < 200) begin
      @(posedge clk); budget++;
    end
    if (dq.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: no completion after %0d cycles", budget);
      dq.delete();
    end
    @(posedge clk);
    check("writes_pending", wq.size(), 0);
    wq.delete();
  endtask

  initial begin
    int t0;
    wr_t w;
    tests = 0; fails = 0; cyc = 0; corrupt = 1'b0; corrupt_addr = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Basic load: 0x11+0x22+0x33+0x44 = 0xAA.
    run_load(32'h010, 4, 64'h44332211, 16'hFFFF, 32'hAA, 0, 1'b0);
    // Wrap-around: 1+2+3+4 = 0x0A, addresses 3FE,3FF,000,001.
    run_load(32'h3FE, 4, 64'h04030201, 16'hFFFF, 32'h0A, 0, 1'b0);
    // Stalled stream 1,0,0,1,1 with a start pulse while busy: 0x60.
    run_load(32'h100, 3, 64'h302010, 16'h0019, 32'h60, 0, 1'b1);
    // Zero length: done in cycle 1, checksum cleared.
    run_load(32'h123, 0, 64'h0, 16'hFFFF, 32'h00, 0, 1'b0);

    // Reset in the cycle after the 2nd of 8 bytes.
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b1; bus.base_addr = 10'h080; bus.len = 11'd8;
    w.cyc = t0 + 2; w.addr = 32'h080; w.data = 32'hC1; wq.push_back(w);
    w.cyc = t0 + 3; w.addr = 32'h081; w.data = 32'hC2; wq.push_back(w);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hC1;
    @(posedge clk); #1;
    bus.in_data = 8'hC2;
    @(posedge clk); #1;
    rst = 1'b1; bus.in_data = 8'hC3;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (4) @(posedge clk);
    check("midreset_writes_pending", wq.size(), 0);
    wq.delete();
    check("mem_080", int'(mem[10'h080]), 32'hC1);
    check("mem_081", int'(mem[10'h081]), 32'hC2);
    check("mem_082", int'(mem[10'h082]), 32'h00);

`ifdef MEM_LOADER_VERIFY_EN
    // 0x5A+0xA5+0x01+0x02 = 0x02; clean read-back then one corrupted byte.
    run_load(32'h040, 4, 64'h0201A55A, 16'hFFFF, 32'h02, 0, 1'b0);
    corrupt = 1'b1; corrupt_addr = 32'h042;
    run_load(32'h040, 4, 64'h0201A55A, 16'hFFFF, 32'h02, 1, 1'b0);
    corrupt = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
